// File: rtl/interleaver_stream_pkg.sv
// Shared types and elaboration helpers for the prime-step streaming interleaver.
package interleaver_stream_pkg;

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  function automatic int frame_len(input int n, input int tail);
    return n + tail;
  endfunction

  function automatic int addr_w(input int n, input int tail);
    int l;
    l = n + tail;
    return (l < 2) ? 1 : $clog2(l);
  endfunction

  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

endpackage

// File: rtl/prime_addr_gen.sv
// Frame address generator: (P*idx) % N by repeated modular add for the first N
// indices, then the index itself for the tail symbols.
module prime_addr_gen
  import interleaver_stream_pkg::*;
#(
  parameter int N         = 10,
  parameter int P         = 3,
  parameter int TAIL_BITS = 0,
  parameter int AW        = addr_w(N, TAIL_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          step,
  output logic [AW-1:0] addr
);

  // One spare bit keeps perm + P below 2N without overflow.
  localparam int PW = $clog2(N) + 1;

  logic [AW-1:0] idx_q, idx_d;
  logic [PW-1:0] perm_q, perm_d, perm_sum;

  always_comb begin
    perm_sum = perm_q + PW'(P);
    idx_d    = idx_q;
    perm_d   = perm_q;
    if (clr) begin
      idx_d  = '0;
      perm_d = '0;
    end else if (step) begin
      idx_d  = idx_q + AW'(1);
      perm_d = (perm_sum >= PW'(N)) ? (perm_sum - PW'(N)) : perm_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      perm_q <= '0;
    end else begin
      idx_q  <= idx_d;
      perm_q <= perm_d;
    end
  end

  assign addr = (int'(idx_q) < N) ? AW'(perm_q) : idx_q;

endmodule

// File: rtl/interleaver_prime_stream.sv
// Ping-pong buffered prime-permutation interleaver, one symbol per cycle.
// Optional in_last framing check enabled by INTERLEAVER_STREAM_FRAMECHK_EN.
module interleaver_prime_stream
  import interleaver_stream_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int N         = 10,
  parameter int P         = 3,
  parameter int TAIL_BITS = 0,
  parameter int REVERSE   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_first,
`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
  output logic            frame_err,
`endif
  output logic            out_last
);

  localparam int   L   = frame_len(N, TAIL_BITS);
  localparam int   AW  = addr_w(N, TAIL_BITS);
  localparam dir_t DIR = (REVERSE != 0) ? REV : FWD;

  if (N < 2 || P <= 0 || P >= N || gcd(P, N) != 1) begin : g_bad_params
    $error("interleaver_prime_stream: need N>=2, 0<P<N and gcd(P,N)==1");
  end

  logic [BITS-1:0] mem_q [2][L];
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0]   wi_q, wi_d, ri_q, ri_d;
  logic            alive_q;
  logic [AW-1:0]   wa, ra, w_perm, r_perm;
  logic            wr_fire, rd_fire, wr_is_last, rd_is_last, wr_end, rd_end, wr_abort;

  // alive_q holds in_ready low through reset without a path from the reset pin.
  assign in_ready   = alive_q && !full_q[wr_bank_q];
  assign out_valid  = full_q[rd_bank_q];
  assign wr_fire    = in_valid && in_ready;
  assign rd_fire    = out_valid && out_ready;
  assign wr_is_last = (wi_q == AW'(L - 1));
  assign rd_is_last = (ri_q == AW'(L - 1));
  assign wr_end     = wr_fire && wr_is_last;
  assign rd_end     = rd_fire && rd_is_last;

`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
  logic frame_err_q;
  assign wr_abort  = wr_fire && in_last && !wr_is_last;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) frame_err_q <= 1'b0;
    else       frame_err_q <= wr_fire && (in_last != wr_is_last);
  end
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign wr_abort       = 1'b0;
`endif

  prime_addr_gen #(.N(N), .P(P), .TAIL_BITS(TAIL_BITS), .AW(AW)) u_wr_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (wr_end || wr_abort),
    .step (wr_fire),
    .addr (w_perm)
  );

  prime_addr_gen #(.N(N), .P(P), .TAIL_BITS(TAIL_BITS), .AW(AW)) u_rd_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (rd_end),
    .step (rd_fire),
    .addr (r_perm)
  );

  assign wa = (DIR == REV) ? w_perm : wi_q;
  assign ra = (DIR == FWD) ? r_perm : ri_q;

  // Write and read sides always work on different banks, so both updates apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wi_d      = wi_q;
    ri_d      = ri_q;
    if (wr_fire) wi_d = wi_q + AW'(1);
    if (wr_end) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
      wi_d              = '0;
    end
    if (wr_abort) wi_d = '0;
    if (rd_fire) ri_d = ri_q + AW'(1);
    if (rd_end) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
      ri_d              = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wi_q      <= '0;
      ri_q      <= '0;
      alive_q   <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wi_q      <= wi_d;
      ri_q      <= ri_d;
      alive_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wa] <= in_data;
  end

  assign out_data  = mem_q[rd_bank_q][ra];
  assign out_first = out_valid && (ri_q == '0);
  assign out_last  = out_valid && rd_is_last;

endmodule

// File: tb/tb_interleaver_prime_stream.sv
// Scoreboard bench: forward interleaver chained into a de-interleaver, plus a
// forward instance with a 3-symbol tail. Covers INTERLEAVER_STREAM_FRAMECHK_EN too.
module tb_interleaver_prime_stream;

  typedef logic [7:0] sym_t;
  typedef sym_t frame_t [10];
  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int tests = 0;
  int failures = 0;

  sym_t inData = '0;
  logic inValid = 1'b0, inLast = 1'b0, inReady;
  sym_t midData;
  logic midValid, midReady, midFirst, midLast;
  logic stallMid = 1'b0;
  logic revInValid, revInReady;
  sym_t revOutData;
  logic revOutValid, revFirst, revLast;
  sym_t tailInData = '0;
  logic tailInValid = 1'b0, tailInLast = 1'b0, tailInReady;
  sym_t tailOutData;
  logic tailOutValid, tailFirst, tailLast;
`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
  logic dutErr, revErr, tailErr;
  int dutErrCount = 0, revErrCount = 0;
`endif

  assign revInValid = midValid && !stallMid;
  assign midReady   = revInReady && !stallMid;

  interleaver_prime_stream #(.BITS(8), .N(10), .P(3), .TAIL_BITS(0), .REVERSE(0)) dut (
    .clk(clk), .reset(reset),
    .in_data(inData), .in_valid(inValid), .in_ready(inReady), .in_last(inLast),
    .out_data(midData), .out_valid(midValid), .out_ready(midReady), .out_first(midFirst),
`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
    .frame_err(dutErr),
`endif
    .out_last(midLast)
  );

  interleaver_prime_stream #(.BITS(8), .N(10), .P(3), .TAIL_BITS(0), .REVERSE(1)) dutRev (
    .clk(clk), .reset(reset),
    .in_data(midData), .in_valid(revInValid), .in_ready(revInReady), .in_last(midLast),
    .out_data(revOutData), .out_valid(revOutValid), .out_ready(1'b1), .out_first(revFirst),
`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
    .frame_err(revErr),
`endif
    .out_last(revLast)
  );

  interleaver_prime_stream #(.BITS(8), .N(10), .P(3), .TAIL_BITS(3), .REVERSE(0)) dutTail (
    .clk(clk), .reset(reset),
    .in_data(tailInData), .in_valid(tailInValid), .in_ready(tailInReady), .in_last(tailInLast),
    .out_data(tailOutData), .out_valid(tailOutValid), .out_ready(1'b1), .out_first(tailFirst),
`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
    .frame_err(tailErr),
`endif
    .out_last(tailLast)
  );

  exp_t midQ[$];
  exp_t finQ[$];
  exp_t tailQ[$];
  exp_t eMid, eFin, eTail;
  int midPops = 0, markPops = 0, markCycle = 0, lastPopCycle = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input sym_t act);
    tests++;
    failures++;
    $display("[TB] FAIL %s: got unexpected symbol %0d, expected no output", name, act);
  endtask

  // Monitors: compare every accepted output against the head of its queue.
  always @(negedge clk) begin
    if (!reset && midValid && midReady) begin
      if (midQ.size() == 0) unexpected("mid out", midData);
      else begin
        eMid = midQ.pop_front();
        checkOutput("mid data", 32'(midData), 32'(eMid.data));
        checkOutput("mid first", 32'(midFirst), 32'(eMid.first));
        checkOutput("mid last", 32'(midLast), 32'(eMid.last));
      end
      if (midPops == markPops) markCycle = cycle;
      midPops++;
      lastPopCycle = cycle;
    end
  end

  always @(negedge clk) begin
    if (!reset && revOutValid) begin
      if (finQ.size() == 0) unexpected("rev out", revOutData);
      else begin
        eFin = finQ.pop_front();
        checkOutput("rev data", 32'(revOutData), 32'(eFin.data));
        checkOutput("rev first", 32'(revFirst), 32'(eFin.first));
        checkOutput("rev last", 32'(revLast), 32'(eFin.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && tailOutValid) begin
      if (tailQ.size() == 0) unexpected("tail out", tailOutData);
      else begin
        eTail = tailQ.pop_front();
        checkOutput("tail data", 32'(tailOutData), 32'(eTail.data));
        checkOutput("tail first", 32'(tailFirst), 32'(eTail.first));
        checkOutput("tail last", 32'(tailLast), 32'(eTail.last));
      end
    end
  end

`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
  always @(negedge clk) begin
    if (!reset && dutErr) dutErrCount++;
    if (!reset && revErr) revErrCount++;
  end
`endif

  function automatic frame_t fwdOf(input frame_t f);
    frame_t o;
    for (int i = 0; i < 10; i++) o[i] = f[(3 * i) % 10];
    return o;
  endfunction

  task automatic pushExpect(input frame_t inF, input frame_t outF);
    for (int i = 0; i < 10; i++) begin
      midQ.push_back('{data: outF[i], first: (i == 0), last: (i == 9)});
      finQ.push_back('{data: inF[i], first: (i == 0), last: (i == 9)});
    end
  endtask

  // Leaves in_valid high so consecutive calls stream back to back.
  task automatic sendSymbol(input sym_t d, input logic last, output int stalls);
    logic got;
    got = 1'b0;
    stalls = 0;
    inValid = 1'b1;
    inData = d;
    inLast = last;
    while (!got && stalls < 200) begin
      @(negedge clk);
      got = inReady;
      @(posedge clk);
      #1;
      if (!got) stalls++;
    end
    if (!got) checkOutput("send timeout", 32'(got), 32'(1));
  endtask

  task automatic applyStimulus(input frame_t inF, input frame_t outF, output int stalls);
    int st;
    stalls = 0;
    pushExpect(inF, outF);
    for (int i = 0; i < 10; i++) begin
      sendSymbol(inF[i], (i == 9), st);
      stalls += st;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((midQ.size() + finQ.size() + tailQ.size()) != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain", 32'(midQ.size() + finQ.size() + tailQ.size()), 32'(0));
  endtask

  frame_t in0, out0, f, bp;
  sym_t tailExp [13];
  int st, stalls, accepted, n;
  logic got, seen;

  initial begin
    in0  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    out0 = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd2, 8'd5, 8'd8, 8'd1, 8'd4, 8'd7};
    tailExp = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd2, 8'd5, 8'd8, 8'd1, 8'd4, 8'd7, 8'd10, 8'd11, 8'd12};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready in reset", 32'(inReady), 32'(0));
    checkOutput("out_valid in reset", 32'(midValid), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready after reset", 32'(inReady), 32'(1));
    checkOutput("out_valid after reset", 32'(midValid), 32'(0));
    checkOutput("out_first after reset", 32'(midFirst), 32'(0));
    checkOutput("out_last after reset", 32'(midLast), 32'(0));
    checkOutput("tail out_valid after reset", 32'(tailOutValid), 32'(0));

    // Directed frame with latency check around the final input symbol.
    pushExpect(in0, out0);
    for (int i = 0; i < 9; i++) sendSymbol(in0[i], 1'b0, st);
    checkOutput("valid before last in", 32'(midValid), 32'(0));
    sendSymbol(in0[9], 1'b1, st);
    inValid = 1'b0;
    inLast = 1'b0;
    checkOutput("valid after last in", 32'(midValid), 32'(1));
    checkOutput("first after last in", 32'(midFirst), 32'(1));
    waitDrain();

    // Tail instance: 0..12.
    for (int i = 0; i < 13; i++)
      tailQ.push_back('{data: tailExp[i], first: (i == 0), last: (i == 12)});
    for (int i = 0; i < 13; i++) begin
      tailInValid = 1'b1;
      tailInData = sym_t'(i);
      tailInLast = (i == 12);
      got = 1'b0;
      n = 0;
      while (!got && n < 200) begin
        @(negedge clk);
        got = tailInReady;
        @(posedge clk);
        #1;
        n++;
      end
      if (!got) checkOutput("tail send timeout", 32'(got), 32'(1));
    end
    tailInValid = 1'b0;
    tailInLast = 1'b0;
    waitDrain();

    // Back-to-back frames at full rate.
    markPops = midPops;
    stalls = 0;
    for (int fr = 0; fr < 4; fr++) begin
      for (int i = 0; i < 10; i++) f[i] = sym_t'(20 + fr * 10 + i);
      applyStimulus(f, fwdOf(f), st);
      if (fr > 0) stalls += st;
    end
    inValid = 1'b0;
    inLast = 1'b0;
    n = 0;
    while (midPops < markPops + 40 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("b2b input stalls", 32'(stalls), 32'(0));
    checkOutput("b2b output span", 32'(lastPopCycle - markCycle), 32'(39));
    waitDrain();

    // Back-pressure: both banks fill, then input is held off.
    stallMid = 1'b1;
    accepted = 0;
    for (int c = 0; c < 25; c++) begin
      inValid = 1'b1;
      inData = sym_t'(100 + accepted);
      inLast = ((accepted % 10) == 9);
      @(negedge clk);
      got = inReady;
      @(posedge clk);
      #1;
      if (got) begin
        bp[accepted % 10] = sym_t'(100 + accepted);
        accepted++;
        if ((accepted % 10) == 0) pushExpect(bp, fwdOf(bp));
      end
    end
    inValid = 1'b0;
    inLast = 1'b0;
    checkOutput("bp accepted", 32'(accepted), 32'(20));
    checkOutput("bp in_ready held", 32'(inReady), 32'(0));
    stallMid = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (midValid && midReady && midLast) seen = 1'b1;
      n++;
    end
    checkOutput("bp frame0 drained", 32'(seen), 32'(1));
    checkOutput("bp in_ready at drain", 32'(inReady), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("bp in_ready after drain", 32'(inReady), 32'(1));
    waitDrain();

    // Random data through the forward/reverse chain.
    for (int fr = 0; fr < 100; fr++) begin
      for (int i = 0; i < 10; i++) f[i] = sym_t'($urandom_range(0, 255));
      applyStimulus(f, fwdOf(f), st);
    end
    inValid = 1'b0;
    inLast = 1'b0;
    waitDrain();

    // Reset while frame 0 drains and frame 1 is half written.
    applyStimulus(in0, out0, st);
    for (int i = 0; i < 5; i++) sendSymbol(sym_t'(50 + i), 1'b0, st);
    reset = 1'b1;
    inValid = 1'b0;
    midQ.delete();
    finQ.delete();
    tailQ.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid-reset out_valid", 32'(midValid), 32'(0));
    checkOutput("mid-reset in_ready", 32'(inReady), 32'(1));
    checkOutput("mid-reset rev out_valid", 32'(revOutValid), 32'(0));
    applyStimulus(in0, out0, st);
    inValid = 1'b0;
    inLast = 1'b0;
    waitDrain();

`ifdef INTERLEAVER_STREAM_FRAMECHK_EN
    // Early in_last on the sixth symbol discards the partial frame.
    for (int i = 0; i < 6; i++) sendSymbol(sym_t'(60 + i), (i == 5), st);
    inValid = 1'b0;
    inLast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("frame_err early", 32'(dutErrCount), 32'(1));
    applyStimulus(in0, out0, st);
    inValid = 1'b0;
    inLast = 1'b0;
    waitDrain();
    checkOutput("frame_err after good frame", 32'(dutErrCount), 32'(1));
    checkOutput("rev frame_err", 32'(revErrCount), 32'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
